// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-cycle logic/add ops, 32-iteration shift/add MULU and DIVU.
// Build option: define ALU_DIV_EN to include the restoring divider; otherwise op 5 reports an error.
module alu_seq_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_high,
    output logic [31:0] rsp_low,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request is taken on a rising edge where req_valid && req_ready;
    // a response is retired on a rising edge where rsp_valid && rsp_ready. Neither
    // valid may depend on its ready, and payloads are only meaningful while valid.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_MULU = 3'd4;
`ifdef ALU_DIV_EN
    localparam logic [2:0] OP_DIVU = 3'd5;
`endif

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] res_high_q, res_high_d;
    logic [31:0] res_low_q, res_low_d;
    logic        err_q, err_d;
`ifdef ALU_DIV_EN
    logic        is_div_q, is_div_d;
`endif

    logic [32:0] add_sum;
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_nxt;
    logic [31:0] mul_lo_nxt;
`ifdef ALU_DIV_EN
    logic [32:0] div_rem_sh;
    logic        div_ge;
    logic [31:0] div_rem_nxt;
    logic [31:0] div_quo_nxt;
`endif

    // Datapath for one engine iteration; the hi/lo accumulator pair is shared.
    always_comb begin
        add_sum    = {1'b0, req_a} + {1'b0, req_b};
        // Multiply: hi:lo holds partial product above the remaining multiplier bits.
        mul_sum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_hi_nxt = mul_sum[32:1];
        mul_lo_nxt = {mul_sum[0], acc_lo_q[31:1]};
`ifdef ALU_DIV_EN
        // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
        // A zero divisor naturally yields all-ones quotient and remainder == dividend.
        div_rem_sh  = {acc_hi_q, acc_lo_q[31]};
        div_ge      = (div_rem_sh >= {1'b0, opnd_q});
        div_rem_nxt = div_ge ? 32'(div_rem_sh - {1'b0, opnd_q}) : div_rem_sh[31:0];
        div_quo_nxt = {acc_lo_q[30:0], div_ge};
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        res_high_d = res_high_q;
        res_low_d  = res_low_q;
        err_d      = err_q;
`ifdef ALU_DIV_EN
        is_div_d   = is_div_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    err_d      = 1'b0;
                    res_high_d = 32'd0;
                    state_d    = ST_DONE;
                    case (req_op)
                        OP_XOR: res_low_d = req_a ^ req_b;
                        OP_AND: res_low_d = req_a & req_b;
                        OP_OR:  res_low_d = req_a | req_b;
                        OP_ADD: begin
                            res_low_d  = add_sum[31:0];
                            res_high_d = {31'd0, add_sum[32]};
                        end
                        OP_MULU: begin
                            opnd_d   = req_a;
                            acc_hi_d = 32'd0;
                            acc_lo_d = req_b;
                            cnt_d    = 5'd31;
                            state_d  = ST_EXEC;
`ifdef ALU_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef ALU_DIV_EN
                        OP_DIVU: begin
                            opnd_d   = req_b;
                            acc_hi_d = 32'd0;
                            acc_lo_d = req_a;
                            cnt_d    = 5'd31;
                            is_div_d = 1'b1;
                            state_d  = ST_EXEC;
                        end
`endif
                        default: begin
                            err_d     = 1'b1;
                            res_low_d = 32'd0;
                        end
                    endcase
                end
            end

            ST_EXEC: begin
                cnt_d = cnt_q - 5'd1;
`ifdef ALU_DIV_EN
                if (is_div_q) begin
                    acc_hi_d = div_rem_nxt;
                    acc_lo_d = div_quo_nxt;
                end else begin
                    acc_hi_d = mul_hi_nxt;
                    acc_lo_d = mul_lo_nxt;
                end
`else
                acc_hi_d = mul_hi_nxt;
                acc_lo_d = mul_lo_nxt;
`endif
                if (cnt_q == 5'd0) begin
                    res_high_d = acc_hi_d;
                    res_low_d  = acc_lo_d;
                    state_d    = ST_DONE;
                end
            end

            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            opnd_q     <= 32'd0;
            acc_hi_q   <= 32'd0;
            acc_lo_q   <= 32'd0;
            res_high_q <= 32'd0;
            res_low_q  <= 32'd0;
            err_q      <= 1'b0;
`ifdef ALU_DIV_EN
            is_div_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            res_high_q <= res_high_d;
            res_low_q  <= res_low_d;
            err_q      <= err_d;
`ifdef ALU_DIV_EN
            is_div_q   <= is_div_d;
`endif
        end
    end

    // Ready is masked by reset so nothing is offered while the block is held.
    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_high  = res_high_q;
    assign rsp_low   = res_low_q;
    assign rsp_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed corner cases, reset abort, then random ops against a reference model.
module tb_alu_seq_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_high;
    logic [31:0] rsp_low;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [64:0] exp_q[$];

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    alu_seq_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_high  (rsp_high),
        .rsp_low   (rsp_low),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference result {err, high, low} straight from the arithmetic definition.
    function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        case (op)
            3'd0: model = {1'b0, 32'd0, a ^ b};
            3'd1: model = {1'b0, 32'd0, a & b};
            3'd2: model = {1'b0, 32'd0, a | b};
            3'd3: begin
                wide  = 64'(a) + 64'(b);
                model = {1'b0, wide};
            end
            3'd4: begin
                wide  = 64'(a) * 64'(b);
                model = {1'b0, wide};
            end
            3'd5: begin
                if (!DIV_EN)     model = {1'b1, 64'd0};
                else if (b == 0) model = {1'b0, a, 32'hFFFF_FFFF};
                else             model = {1'b0, a % b, a / b};
            end
            default: model = {1'b1, 64'd0};
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op);
        latency = (op == 3'd4 || (op == 3'd5 && DIV_EN)) ? 32 : 0;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit early);
        logic [64:0] exp;
        int          lat;
        logic [31:0] hh;
        logic [31:0] ll;
        logic        ee;
        @(negedge clock);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        exp_q.push_back(model(op, a, b));
        rsp_ready = early;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(latency(op)));
        exp = exp_q.pop_front();
        check("rsp_high", 64'(rsp_high), 64'(exp[63:32]));
        check("rsp_low", 64'(rsp_low), 64'(exp[31:0]));
        check("rsp_err", 64'(rsp_err), 64'(exp[64]));
        check("busy_done", 64'(busy), 64'd1);
        hh = exp[63:32];
        ll = exp[31:0];
        ee = exp[64];
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                #1;
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_req_ready", 64'(req_ready), 64'd0);
                check("hold_data", {rsp_high, rsp_low}, {hh, ll});
                check("hold_err", 64'(rsp_err), 64'(ee));
            end
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        check("consumed_valid", 64'(rsp_valid), 64'd0);
        check("consumed_req_ready", 64'(req_ready), 64'd1);
        check("consumed_busy", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       pick_operand = 32'd0;
            1:       pick_operand = 32'hFFFF_FFFF;
            2:       pick_operand = 32'($urandom_range(0, 255));
            default: pick_operand = $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", {rsp_high, rsp_low}, 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        run_op(3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1'b0);
        run_op(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 0, 1'b0);
        run_op(3'd5, 32'h1234_5678, 32'd0, 2, 1'b0);
        run_op(3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0);
        run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
        run_op(3'd1, 32'hA5A5_A5A5, 32'h0FF0_0FF0, 0, 1'b1);
        run_op(3'd2, 32'hA5A5_0000, 32'h0000_5A5A, 0, 1'b0);

        // Abort a multiply partway through with an asynchronous reset.
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_a     = 32'h0001_0003;
        req_b     = 32'h0002_0005;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("mid_exec_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd0);
        check("abort_rsp_data", {rsp_high, rsp_low}, 64'd0);
        check("abort_rsp_err", 64'(rsp_err), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        run_op(3'd3, 32'd2, 32'd3, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check("no_stale_valid", 64'(rsp_valid), 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer for the 32-bit ALU datapath that produces a high/low result pair. It accepts one operation at a time over a valid/ready request port. Single-cycle logic and add ops complete in one cycle. Unsigned multiply and divide are iterated over 32 cycles in a shift/add engine. Results are held on a valid/ready response port until they are consumed. The block sits between the core's execute-stage control and the register-file writeback of res_high/res_low.

## Interface
Parameters:
- none; data width is fixed at 32, and iteration count is fixed at 32.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  3  0 XOR, 1 AND, 2 OR, 3 ADD, 4 MULU, 5 DIVU, 6–7 illegal.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_high  out  32  high result word.
- rsp_low  out  32  low result word.
- rsp_err  out  1  illegal or unsupported op.
- busy  out  1  high in EXEC or DONE.

## Operation
- The FSM has three states: IDLE, EXEC and DONE. The reset state is IDLE.
- Accept: req_valid && req_ready. req_a, req_b and req_op are captured at the accept edge, and later input changes are ignored.
- IDLE → DONE on accept of op 0–3, 6–7, or op 5 when divide is compiled out. The result is registered at the accept edge.
- IDLE → EXEC on accept of MULU, or DIVU when divide is compiled in. The iteration counter loads 31.
- EXEC performs one iteration per cycle and decrements the counter. The iteration at counter 0 writes the final result and moves the FSM to DONE.
- DONE → IDLE on rsp_valid && rsp_ready. Response outputs hold stable while rsp_ready is low.
- XOR/AND/OR: rsp_low = bitwise result, rsp_high = 0.
- ADD: rsp_low = (a+b)[31:0], rsp_high = {31'b0, carry-out}.
- MULU: {rsp_high, rsp_low} = unsigned 64-bit a*b, computed by a radix-2 shift-add engine.
- DIVU: restoring division, with rsp_low = quotient and rsp_high = remainder.
  - If b==0: rsp_low = 0xFFFFFFFF, rsp_high = a, and the full 32 cycles are still spent.
- Illegal op: rsp_err=1, rsp_high = rsp_low = 0. rsp_err is 0 for all legal ops.
- busy = (state != IDLE).

## Timing
- Reset values: req_ready=0 while reset is asserted and 1 in IDLE after release. rsp_valid=0, rsp_high=0, rsp_low=0, rsp_err=0, busy=0.
- Single-cycle op: accepted at edge N, rsp_valid high from edge N onward (1-cycle latency).
- MULU/DIVU: accepted at edge N, rsp_valid high from edge N+32 (32-cycle latency).
- Response consumed at edge M: req_ready is high from edge M. The earliest next accept is at edge M+1.
- There is no accept in the same cycle as a response handshake, so peak single-cycle throughput is one op per 2 cycles.
- Reset asserted mid-EXEC or in DONE: the operation is aborted, the pending response is discarded, and all outputs go to their reset values immediately.
- rsp_ready held high in advance: the response is consumed on the first cycle rsp_valid is high.

## Configuration
- ALU_DIV_EN defined: DIVU (op 5) runs in the 32-cycle engine as specified above.
- ALU_DIV_EN undefined: the divide logic is removed. Op 5 is treated as illegal, giving rsp_err=1, zero results and 1-cycle latency. MULU is unaffected.

## Test plan
- XOR a=0xF0F0F0F0, b=0xFF00FF00 → rsp_low=0x0FF00FF0, rsp_high=0, rsp_err=0, rsp_valid 1 cycle after accept.
- ADD a=0xFFFFFFFF, b=0x00000001 → rsp_low=0, rsp_high=1.
- MULU a=b=0xFFFFFFFF → rsp_high=0xFFFFFFFE, rsp_low=0x00000001 at 32 cycles. Hold rsp_ready low for 5 cycles and check the outputs stay stable and req_ready stays 0.
- DIVU a=100, b=7 → rsp_low=14, rsp_high=2. DIVU a=0x12345678, b=0 → rsp_low=0xFFFFFFFF, rsp_high=0x12345678 (run with ALU_DIV_EN).
- Op 6, and op 5 without ALU_DIV_EN → rsp_err=1 and zero results, 1-cycle latency.
- Reset pulse at cycle 10 of a MULU → busy=0 and rsp_valid=0 immediately. A following ADD 2+3 returns rsp_low=5 and no stale response appears.
